// File: rtl/serial_adder_seq.sv
// Bit-serial WIDTH-bit adder that time-multiplexes one NOR full-adder cell, LSB first.
// Optional subtract mode: define SERIAL_ADDER_SUB_EN to add the `sub` input.

module adder (
    input  logic a,
    input  logic b,
    input  logic carry_in,
    output logic result,
    output logic carry_out
);
    logic w_n1, w_n2, w_n3, w_xnor_ab;
    logic w_m1, w_m2, w_m3;
    logic w_na, w_nb, w_ab, w_nc;

    // XNOR(a,b) from four NORs; repeating the structure with carry_in yields the sum
    assign w_n1      = ~(a | b);
    assign w_n2      = ~(a | w_n1);
    assign w_n3      = ~(b | w_n1);
    assign w_xnor_ab = ~(w_n2 | w_n3);
    assign w_m1      = ~(w_xnor_ab | carry_in);
    assign w_m2      = ~(w_xnor_ab | w_m1);
    assign w_m3      = ~(carry_in | w_m1);
    assign result    = ~(w_m2 | w_m3);

    assign w_na      = ~(a | a);
    assign w_nb      = ~(b | b);
    assign w_ab      = ~(w_na | w_nb);
    assign w_nc      = ~(w_ab | w_m2);
    assign carry_out = ~(w_nc | w_nc);
endmodule

module serial_adder_seq #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out
`ifdef SERIAL_ADDER_SUB_EN
    ,
    input  logic             sub
`endif
);
    localparam int unsigned     CntW    = $clog2(WIDTH);
    localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           r_state;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:1] r_res_sh;
    logic             r_c;
    logic [CntW-1:0]  r_cnt;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_result;
    logic             r_carry_out;

    logic             w_sum;
    logic             w_cout;
    logic             w_accept;
    logic [WIDTH-1:0] w_b_load;
    logic             w_c_load;
    logic [WIDTH-1:0] w_res_next;

`ifdef SERIAL_ADDER_SUB_EN
    // a - b computed as a + ~b + 1
    assign w_b_load = sub ? ~b : b;
    assign w_c_load = sub ? 1'b1 : carry_in;
`else
    assign w_b_load = b;
    assign w_c_load = carry_in;
`endif

    assign w_accept   = start && (r_state != StRun);
    assign w_res_next = {w_sum, r_res_sh};

    adder u_cell (
        .a         (r_a_sh[0]),
        .b         (r_b_sh[0]),
        .carry_in  (r_c),
        .result    (w_sum),
        .carry_out (w_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= StIdle;
            r_a_sh      <= '0;
            r_b_sh      <= '0;
            r_res_sh    <= '0;
            r_c         <= 1'b0;
            r_cnt       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_result    <= '0;
            r_carry_out <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_a_sh  <= a;
                r_b_sh  <= w_b_load;
                r_c     <= w_c_load;
                r_cnt   <= '0;
                r_busy  <= 1'b1;
                r_state <= StRun;
            end else begin
                case (r_state)
                    StRun: begin
                        r_a_sh   <= r_a_sh >> 1;
                        r_b_sh   <= r_b_sh >> 1;
                        r_res_sh <= w_res_next[WIDTH-1:1];
                        r_c      <= w_cout;
                        r_cnt    <= r_cnt + CntW'(1);
                        if (r_cnt == LastBit) begin
                            r_result    <= w_res_next;
                            r_carry_out <= w_cout;
                            r_busy      <= 1'b0;
                            r_done      <= 1'b1;
                            r_state     <= StDone;
                        end
                    end
                    default: r_state <= StIdle;
                endcase
            end
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign result    = r_result;
    assign carry_out = r_carry_out;
endmodule

// File: doc/serial_adder_seq.md
# serial_adder_seq

Bit-serial multi-bit adder that sequences the one-bit NOR full-adder cell `adder` over WIDTH clock cycles. It latches two WIDTH-bit operands and a carry-in, feeds one bit pair per cycle (LSB first) into a single cell instance, and recirculates the cell's carry through a flip-flop. It sits directly upstream of, and drives, that cell, trading latency for a one-cell datapath.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 2..32.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only when busy=0.
- a  in  WIDTH  operand A; captured on the accepting edge.
- b  in  WIDTH  operand B; captured on the accepting edge.
- carry_in  in  1  initial carry; captured on the accepting edge.
- busy  out  1  high while an addition is in progress.
- done  out  1  single-cycle completion pulse.
- result  out  WIDTH  sum, registered; held until the next completion.
- carry_out  out  1  final carry, registered; held until the next completion.
- sub  in  1  present only with SERIAL_ADDER_SUB_EN; see Configuration.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE: busy=0. If start=1, load shift registers a_sh<=a, b_sh<=b, carry register c<=carry_in, bit counter<=0, then go to RUN.
  - RUN: busy=1. One cell instance gets a=a_sh[0], b=b_sh[0], carry_in=c.
    - Each edge: a_sh and b_sh shift right; cell result shifts into res_sh MSB; c<=cell carry_out; counter increments.
    - On the edge that processes bit WIDTH-1: result<={cell result, res_sh[WIDTH-1:1]}, carry_out<=cell carry_out, go to DONE.
  - DONE: done=1 and busy=0 for exactly one cycle. start=1 here is accepted exactly as in IDLE (back-to-back); otherwise go to IDLE.
- start while busy=1 is ignored. Operands are not re-sampled mid-operation.
- Counter width: $clog2(WIDTH). Sum is modulo 2^WIDTH; overflow appears only on carry_out.
- result and carry_out change only on the completing edge, at reset, or (never otherwise).

## Timing
- Accepting edge E0; bit i is processed at edge E(i+1).
- result, carry_out and done are valid from edge E_WIDTH, i.e. WIDTH cycles after acceptance.
- busy rises at E0 and falls at E_WIDTH.
- Throughput: one addition per WIDTH+1 cycles; back-to-back start in the DONE cycle gives exactly WIDTH+1.
- Reset (any state, including mid-RUN):
  - next edge gives IDLE, busy=0, done=0, result=0, carry_out=0;
  - shift registers, c and counter are cleared;
  - the in-flight operation is discarded with no done pulse.
- rst has priority over start on the same edge.

## Configuration
- SERIAL_ADDER_SUB_EN defined:
  - adds input `sub`, captured with the operands;
  - when sub=1, b_sh is loaded with ~b and c with 1 (ignoring carry_in), so result=a-b mod 2^WIDTH and carry_out=1 means no borrow;
  - when sub=0, behaviour is identical to the add-only build.
- SERIAL_ADDER_SUB_EN undefined: no `sub` port; add only.

## Test plan
- Add: WIDTH=8, a=0x5A, b=0x33, carry_in=0, start pulse -> exactly 8 cycles later done=1, result=0x8D, carry_out=0; busy high for those 8 cycles.
- Carry chain: a=0xFF, b=0x01, carry_in=0 -> result=0x00, carry_out=1. Also a=0xFF, b=0x00, carry_in=1 -> result=0x00, carry_out=1.
- Busy/back-to-back:
  - start a=0x01, b=0x01, then start again at cycle 3 with a=0xF0 -> ignored, result=0x02;
  - start a=0x10, b=0x20 in the DONE cycle -> second done exactly 9 cycles after the first, result=0x30.
- Reset mid-op: start a=0x5A, b=0x33, assert rst at cycle 4 -> next edge busy=0, result=0x00, carry_out=0; no done pulse follows.
- Subtract (SERIAL_ADDER_SUB_EN): sub=1, a=0x10, b=0x01 -> result=0x0F, carry_out=1. Then a=0x00, b=0x01 -> result=0xFF, carry_out=0.
